r88_fetch: RTL and testbench
============================

Name: r88_fetch

Overview:
- Instruction fetch and prefetch queue for the Rocket88 core; sits directly upstream of the instruction decoder.
- Owns the architectural PC and issues byte reads to memory, one outstanding request at a time.
- Buffers returned bytes in a small FIFO and presents the head byte on intD with a valid flag.
- The decoder consumes bytes with incPC and redirects fetch with loadPC/newPC on jumps, interrupts and reset vectors.

Parameters:
- DEPTH, 4, prefetch queue entries; power of 2, 2..16.
- RESET_PC, 16'h0000, fetch address and PC after reset.

Ports:
- sysClock  in  1  system clock; all state updates on its rising edge.
- sysResetN  in  1  asynchronous, active-low reset.
- readMem  out  1  memory read request.
- memAddr  out  16  read address; valid while readMem=1.
- memAck  in  1  memory completed the current read this cycle.
- memData  in  8  read data; valid when memAck=1.
- fetchHold  in  1  decoder needs the bus; no new request may start.
- intD  out  8  queue head byte; 8'h00 when byteValid=0.
- byteValid  out  1  queue non-empty (or bypass hit, see Optional Feature).
- incPC  in  1  decoder consumes the head byte; ignored when byteValid=0.
- loadPC  in  1  redirect: flush queue and fetch from newPC.
- newPC  in  16  redirect target.
- pcOut  out  16  address of the byte currently on intD.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - state=IDLE, readMem=0, memAddr=RESET_PC, fetchAddr=RESET_PC, pcOut=RESET_PC.
  - count=0, byteValid=0, intD=8'h00.
  - An in-flight request is abandoned; the memory side tolerates a dropped ack.
- State IDLE:
  - Goes to FETCH when fetchHold=0, count<DEPTH and loadPC=0.
  - In that same edge, readMem goes to 1 and memAddr to fetchAddr (the current, not the incremented, address).
- State FETCH:
  - readMem=1; memAddr holds stable until memAck.
  - On memAck: push memData and set fetchAddr=fetchAddr+1, wrapping 16'hFFFF to 16'h0000.
  - After the ack, stay in FETCH (back-to-back) with memAddr=new fetchAddr if count_next<DEPTH and fetchHold=0.
  - Otherwise go to IDLE with readMem=0.
- State DISCARD (entered on loadPC while a request is pending without an ack):
  - readMem=1 and the old memAddr are held until memAck.
  - The returned data is dropped, then the block goes to IDLE.
- loadPC (highest priority):
  - Next cycle: count=0, fetchAddr=newPC, pcOut=newPC.
  - An incPC in the same cycle is ignored.
  - If memAck arrives in the same cycle, the data is dropped and the block goes to IDLE; no DISCARD needed.
  - loadPC while in DISCARD updates the target only; DISCARD continues.
- Queue:
  - Circular buffer with a count of 0..DEPTH.
  - Push and pop in the same cycle leave count unchanged.
  - While count=DEPTH no new request is issued. The FETCH back-to-back check uses count_next, so a pop in the ack cycle permits continuation.
- Pop (incPC=1 with byteValid=1): pcOut=pcOut+1, wrapping at 16 bits.
- Latency: the ack byte appears on intD one cycle after memAck. This is the minimum fetch-to-decode latency of 2 cycles from request start with a zero-wait memory.
- fetchHold never aborts an outstanding request; it only blocks new ones.

Optional Feature:
- Macro R88_FETCH_BYPASS_EN.
- Defined:
  - When count=0, state=FETCH, memAck=1 and loadPC=0, memData drives intD and byteValid=1 combinationally in that cycle.
  - If incPC=1 in that cycle, the byte is consumed (pcOut+1) and not written to the queue; otherwise it is pushed normally.
- Undefined: no bypass; byteValid depends only on count, with the fixed one-cycle ack-to-intD latency.

Test Plan:
- Reset then release, fetchHold=0, memory returns ack one cycle after each request, no incPC:
  - addresses 0000,0001,0002,0003 are read.
  - Queue fills to 4 and readMem drops to 0.
  - intD=byte@0000, pcOut=0000.
- Full queue, incPC held high with continuous acks:
  - one byte per cycle with pcOut incrementing.
  - Fetch resumes in the cycle a slot frees; no dropped or duplicated bytes.
- loadPC newPC=8000 while a request to 0005 is pending:
  - readMem stays high at 0005 until ack, and that byte never appears.
  - The next request is 8000 and pcOut=8000.
- Wrap: loadPC newPC=FFFE, fetch 3 bytes:
  - memAddr sequence FFFE,FFFF,0000.
  - After 2 pops pcOut=0000.
- fetchHold=1 asserted mid-FETCH:
  - the current ack completes and the byte is pushed, then readMem=0.
  - Deasserting fetchHold resumes at the next address.
- Bypass, with the macro defined, empty queue, memAck with data 3C and incPC in the same cycle:
  - intD=3C and byteValid=1 that cycle; count stays 0 and pcOut increments.
  - Without the macro, intD=3C appears one cycle later.

Source files
------------

// File: rtl/r88_fetch_if.sv
// r88_fetch_if: memory and decoder bundle of the Rocket88 fetch unit.
// Fetch is master; memory/decoder side is slave.
interface r88_fetch_if;
  logic        readMem;
  logic [15:0] memAddr;
  logic        memAck;
  logic [7:0]  memData;
  logic        fetchHold;
  logic [7:0]  intD;
  logic        byteValid;
  logic        incPC;
  logic        loadPC;
  logic [15:0] newPC;
  logic [15:0] pcOut;

  modport master (
    output readMem,
    output memAddr,
    input  memAck,
    input  memData,
    input  fetchHold,
    output intD,
    output byteValid,
    input  incPC,
    input  loadPC,
    input  newPC,
    output pcOut
  );

  modport slave (
    input  readMem,
    input  memAddr,
    output memAck,
    output memData,
    output fetchHold,
    input  intD,
    input  byteValid,
    output incPC,
    output loadPC,
    output newPC,
    input  pcOut
  );
endinterface

// File: rtl/r88_fetch.sv
// r88_fetch: Rocket88 PC owner, byte fetcher and prefetch queue.
// Define R88_FETCH_BYPASS_EN to forward an ack byte straight to intD.
module r88_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        sysClock,
  input  logic        sysResetN,
  r88_fetch_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] FETCH   = 2'd1;
  localparam logic [1:0] DISCARD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   fa_q, fa_d;
  logic [15:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [7:0]    buf_q [DEPTH];

  logic empty;
  logic ack;
  logic bypass;
  logic pop;
  logic deq;
  logic push;

  assign empty = (cnt_q == '0);
  assign ack   = bus.memAck && (state_q != IDLE);

`ifdef R88_FETCH_BYPASS_EN
  assign bypass = empty && (state_q == FETCH)
               && bus.memAck && !bus.loadPC;
`else
  assign bypass = 1'b0;
`endif

  assign bus.byteValid = !empty || bypass;
  assign bus.readMem   = (state_q != IDLE);
  assign bus.memAddr   = addr_q;
  assign bus.pcOut     = pc_q;

  always_comb begin
    bus.intD = 8'h00;
    if (!empty) begin
      bus.intD = buf_q[rd_q];
    end else if (bypass) begin
      bus.intD = bus.memData;
    end
  end

  // A redirect wins over any consume in the same cycle.
  assign pop  = bus.incPC && bus.byteValid && !bus.loadPC;
  assign deq  = pop && !empty;
  // Bypassed byte taken immediately never enters the queue.
  assign push = (state_q == FETCH) && ack && !bus.loadPC
             && !(pop && empty);

  always_comb begin
    cnt_d = cnt_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    if (bus.loadPC) begin
      cnt_d = '0;
      rd_d  = '0;
      wr_d  = '0;
    end else begin
      unique case ({push, deq})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      rd_d = rd_q + AW'(deq);
      wr_d = wr_q + AW'(push);
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (bus.loadPC) begin
      pc_d = bus.newPC;
    end else if (pop) begin
      pc_d = pc_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fa_d    = fa_q;
    unique case (state_q)
      IDLE: begin
        if (bus.loadPC) begin
          fa_d = bus.newPC;
        end else if (!bus.fetchHold && cnt_q < FULL) begin
          state_d = FETCH;
          addr_d  = fa_q;
        end
      end
      FETCH: begin
        if (bus.loadPC) begin
          fa_d    = bus.newPC;
          state_d = ack ? IDLE : DISCARD;
        end else if (ack) begin
          fa_d = fa_q + 16'd1;
          if (cnt_d < FULL && !bus.fetchHold) begin
            addr_d = fa_q + 16'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DISCARD: begin
        // Old request must finish; its byte is dropped.
        if (bus.loadPC) begin
          fa_d = bus.newPC;
        end
        if (ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state_q <= IDLE;
      addr_q  <= RESET_PC;
      fa_q    <= RESET_PC;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      fa_q    <= fa_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        buf_q[i] <= 8'h00;
      end
    end else if (push) begin
      buf_q[wr_q] <= bus.memData;
    end
  end

endmodule

// File: tb/tb_r88_fetch.sv
// tb_r88_fetch: scenario tasks plus random run against a queue model.
// Build with R88_FETCH_BYPASS_EN to check the bypass variant.
module tb_r88_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic sysClock;
  logic sysResetN;

  r88_fetch_if bus ();

  r88_fetch #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .sysClock  (sysClock),
    .sysResetN (sysResetN),
    .bus       (bus)
  );

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  int errors = 0;
  int checks = 0;
  int ack_pct = 100;

  logic [7:0] mem [0:65535];

  // Behavioural model: pending request, fetch pointer, PC and byte queue.
  bit          m_pend;
  bit          m_disc;
  logic [15:0] m_addr;
  logic [15:0] m_fa;
  logic [15:0] m_pc;
  logic [7:0]  m_q [$];

  function automatic bit m_byp();
`ifdef R88_FETCH_BYPASS_EN
    return (m_q.size() == 0) && m_pend && !m_disc
        && bus.memAck && !bus.loadPC;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_bv();
    return (m_q.size() != 0) || m_byp();
  endfunction

  function automatic logic [7:0] exp_intd();
    if (m_q.size() != 0) return m_q[0];
    if (m_byp()) return mem[m_addr];
    return 8'h00;
  endfunction

  task automatic m_reset();
    m_pend = 0;
    m_disc = 0;
    m_addr = RESET_PC;
    m_fa   = RESET_PC;
    m_pc   = RESET_PC;
    m_q.delete();
  endtask

  task automatic m_update();
    bit ack;
    bit byp;
    int n0;
    ack = bus.memAck && m_pend;
    byp = m_byp();
    n0  = m_q.size();
    if (bus.loadPC) begin
      m_q.delete();
      m_pc = bus.newPC;
      m_fa = bus.newPC;
      if (ack) begin
        m_pend = 0;
        m_disc = 0;
      end else if (m_pend) begin
        m_disc = 1;
      end
    end else begin
      if (bus.incPC && (n0 > 0 || byp)) begin
        m_pc = m_pc + 16'd1;
        if (n0 > 0) void'(m_q.pop_front());
      end
      if (ack && m_disc) begin
        m_pend = 0;
        m_disc = 0;
      end else if (ack) begin
        if (!(byp && bus.incPC)) m_q.push_back(mem[m_addr]);
        m_fa = m_fa + 16'd1;
        if (m_q.size() < DEPTH && !bus.fetchHold) m_addr = m_fa;
        else m_pend = 0;
      end else if (!m_pend && !bus.fetchHold && n0 < DEPTH) begin
        m_pend = 1;
        m_addr = m_fa;
      end
    end
  endtask

  // Advance one clock; memory answers at the falling edge.
  task automatic tick();
    m_update();
    @(negedge sysClock);
    bus.memAck = bus.readMem && ($urandom_range(0, 99) < ack_pct);
    bus.memData = bus.memAck ? mem[bus.memAddr] : 8'($urandom);
    #1;
  endtask

  task automatic drain();
    bus.fetchHold = 1'b1;
    bus.incPC     = 1'b0;
    bus.loadPC    = 1'b0;
    ack_pct       = 100;
    for (int i = 0; i < 12 && m_pend; i++) tick();
  endtask

  task automatic test_reset();
    sysResetN     = 1'b0;
    bus.memAck    = 1'b0;
    bus.memData   = 8'h00;
    bus.fetchHold = 1'b0;
    bus.incPC     = 1'b0;
    bus.loadPC    = 1'b0;
    bus.newPC     = 16'h0000;
    repeat (2) @(negedge sysClock);
    #1;
    checks++; if (bus.readMem !== 1'b0) begin errors++; $display("FAIL reset_readMem: got %b want 0", bus.readMem); end
    checks++; if (bus.memAddr !== RESET_PC) begin errors++; $display("FAIL reset_memAddr: got %h want %h", bus.memAddr, RESET_PC); end
    checks++; if (bus.pcOut !== RESET_PC) begin errors++; $display("FAIL reset_pcOut: got %h want %h", bus.pcOut, RESET_PC); end
    checks++; if (bus.byteValid !== 1'b0) begin errors++; $display("FAIL reset_byteValid: got %b want 0", bus.byteValid); end
    checks++; if (bus.intD !== 8'h00) begin errors++; $display("FAIL reset_intD: got %h want 00", bus.intD); end
    sysResetN = 1'b1;
    m_reset();
  endtask

  task automatic test_fill();
    logic [15:0] req [$];
    ack_pct = 100;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++; if (bus.readMem !== m_pend) begin errors++; $display("FAIL fill_readMem c%0d: got %b want %b", c, bus.readMem, m_pend); end
      if (bus.readMem && bus.memAck) req.push_back(bus.memAddr);
    end
    checks++; if (req.size() !== 4) begin errors++; $display("FAIL fill_reqs: got %0d want 4", req.size()); end
    for (int i = 0; i < req.size() && i < 4; i++) begin
      checks++; if (req[i] !== 16'(RESET_PC + i)) begin errors++; $display("FAIL fill_addr%0d: got %h want %h", i, req[i], 16'(RESET_PC + i)); end
    end
    checks++; if (bus.readMem !== 1'b0) begin errors++; $display("FAIL fill_full_readMem: got %b want 0", bus.readMem); end
    checks++; if (bus.byteValid !== 1'b1) begin errors++; $display("FAIL fill_byteValid: got %b want 1", bus.byteValid); end
    checks++; if (bus.intD !== mem[RESET_PC]) begin errors++; $display("FAIL fill_intD: got %h want %h", bus.intD, mem[RESET_PC]); end
    checks++; if (bus.pcOut !== RESET_PC) begin errors++; $display("FAIL fill_pcOut: got %h want %h", bus.pcOut, RESET_PC); end
  endtask

  task automatic test_stream();
    logic [15:0] pc;
    pc = RESET_PC;
    ack_pct = 100;
    bus.incPC = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      checks++; if (bus.byteValid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %b want 1", c, bus.byteValid); end
      checks++; if (bus.pcOut !== pc) begin errors++; $display("FAIL stream_pc c%0d: got %h want %h", c, bus.pcOut, pc); end
      checks++; if (bus.intD !== mem[pc]) begin errors++; $display("FAIL stream_byte c%0d: got %h want %h", c, bus.intD, mem[pc]); end
      checks++; if (bus.readMem !== m_pend) begin errors++; $display("FAIL stream_readMem c%0d: got %b want %b", c, bus.readMem, m_pend); end
      pc = pc + 16'd1;
      tick();
    end
    bus.incPC = 1'b0;
  endtask

  task automatic test_redirect();
    drain();
    bus.fetchHold = 1'b0;
    ack_pct = 0;
    bus.loadPC = 1'b1;
    bus.newPC  = 16'h0005;
    #1; tick();
    bus.loadPC = 1'b0;
    #1; tick();
    bus.loadPC = 1'b1;
    bus.newPC  = 16'h8000;
    #1;
    checks++; if (bus.readMem !== 1'b1 || bus.memAddr !== 16'h0005) begin errors++; $display("FAIL redir_pending: got %b/%h want 1/0005", bus.readMem, bus.memAddr); end
    tick();
    bus.loadPC = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (bus.readMem !== 1'b1 || bus.memAddr !== 16'h0005) begin errors++; $display("FAIL redir_hold c%0d: got %b/%h want 1/0005", c, bus.readMem, bus.memAddr); end
      checks++; if (bus.byteValid !== 1'b0) begin errors++; $display("FAIL redir_empty c%0d: got %b want 0", c, bus.byteValid); end
      if (c == 3) ack_pct = 100;
      tick();
    end
    checks++; if (bus.memAck !== 1'b1 || bus.memAddr !== 16'h0005) begin errors++; $display("FAIL redir_ack: got %b/%h want 1/0005", bus.memAck, bus.memAddr); end
    tick();
    checks++; if (bus.readMem !== 1'b0) begin errors++; $display("FAIL redir_idle: got %b want 0", bus.readMem); end
    tick();
    checks++; if (bus.readMem !== 1'b1 || bus.memAddr !== 16'h8000) begin errors++; $display("FAIL redir_newreq: got %b/%h want 1/8000", bus.readMem, bus.memAddr); end
    tick();
    checks++; if (bus.pcOut !== 16'h8000) begin errors++; $display("FAIL redir_pc: got %h want 8000", bus.pcOut); end
    checks++; if (bus.byteValid !== 1'b1 || bus.intD !== 8'h18) begin errors++; $display("FAIL redir_byte: got %b/%h want 1/18", bus.byteValid, bus.intD); end
  endtask

  task automatic test_wrap();
    logic [15:0] req [$];
    drain();
    bus.fetchHold = 1'b0;
    bus.loadPC = 1'b1;
    bus.newPC  = 16'hFFFE;
    #1; tick();
    bus.loadPC = 1'b0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (bus.readMem && bus.memAck) req.push_back(bus.memAddr);
      tick();
    end
    checks++; if (req.size() < 3) begin errors++; $display("FAIL wrap_reqs: got %0d want >=3", req.size()); end
    for (int i = 0; i < req.size() && i < 3; i++) begin
      checks++; if (req[i] !== 16'(16'hFFFE + i)) begin errors++; $display("FAIL wrap_addr%0d: got %h want %h", i, req[i], 16'(16'hFFFE + i)); end
    end
    bus.incPC = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (bus.byteValid !== 1'b1 || bus.intD !== mem[16'(16'hFFFE + c)]) begin errors++; $display("FAIL wrap_pop%0d: got %b/%h want 1/%h", c, bus.byteValid, bus.intD, mem[16'(16'hFFFE + c)]); end
      tick();
    end
    bus.incPC = 1'b0;
    #1;
    checks++; if (bus.pcOut !== 16'h0000) begin errors++; $display("FAIL wrap_pc: got %h want 0000", bus.pcOut); end
  endtask

  task automatic test_hold();
    drain();
    bus.fetchHold = 1'b0;
    bus.loadPC = 1'b1;
    bus.newPC  = 16'h1000;
    #1; tick();
    bus.loadPC = 1'b0;
    #1; tick();
    bus.fetchHold = 1'b1;
    #1;
    checks++; if (bus.readMem !== 1'b1 || bus.memAddr !== 16'h1000 || bus.memAck !== 1'b1) begin errors++; $display("FAIL hold_req: got %b/%h/%b want 1/1000/1", bus.readMem, bus.memAddr, bus.memAck); end
    tick();
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (bus.readMem !== 1'b0) begin errors++; $display("FAIL hold_idle c%0d: got %b want 0", c, bus.readMem); end
      tick();
    end
    checks++; if (bus.byteValid !== 1'b1 || bus.intD !== mem[16'h1000]) begin errors++; $display("FAIL hold_byte: got %b/%h want 1/%h", bus.byteValid, bus.intD, mem[16'h1000]); end
    bus.fetchHold = 1'b0;
    #1; tick();
    checks++; if (bus.readMem !== 1'b1 || bus.memAddr !== 16'h1001) begin errors++; $display("FAIL hold_resume: got %b/%h want 1/1001", bus.readMem, bus.memAddr); end
  endtask

  task automatic test_bypass();
    drain();
    bus.fetchHold = 1'b0;
    bus.loadPC = 1'b1;
    bus.newPC  = 16'h2000;
    #1; tick();
    bus.loadPC = 1'b0;
    #1; tick();
    bus.incPC = 1'b1;
    #1;
`ifdef R88_FETCH_BYPASS_EN
    checks++; if (bus.byteValid !== 1'b1 || bus.intD !== 8'h3C) begin errors++; $display("FAIL byp_hit: got %b/%h want 1/3c", bus.byteValid, bus.intD); end
`else
    checks++; if (bus.byteValid !== 1'b0 || bus.intD !== 8'h00) begin errors++; $display("FAIL byp_none: got %b/%h want 0/00", bus.byteValid, bus.intD); end
`endif
    ack_pct = 0;
    tick();
    bus.incPC = 1'b0;
    #1;
`ifdef R88_FETCH_BYPASS_EN
    checks++; if (bus.byteValid !== 1'b0 || bus.pcOut !== 16'h2001) begin errors++; $display("FAIL byp_after: got %b/%h want 0/2001", bus.byteValid, bus.pcOut); end
`else
    checks++; if (bus.byteValid !== 1'b1 || bus.intD !== 8'h3C || bus.pcOut !== 16'h2000) begin errors++; $display("FAIL byp_late: got %b/%h/%h want 1/3c/2000", bus.byteValid, bus.intD, bus.pcOut); end
`endif
  endtask

  task automatic test_random();
    ack_pct = 60;
    bus.loadPC = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bus.incPC     = 1'($urandom_range(0, 1));
      bus.fetchHold = ($urandom_range(0, 4) == 0);
      bus.loadPC    = ($urandom_range(0, 39) == 0);
      bus.newPC     = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'(16'hFFFC + $urandom_range(0, 3));
      #1;
      checks++; if (bus.readMem !== m_pend) begin errors++; $display("FAIL rnd_readMem c%0d: got %b want %b", c, bus.readMem, m_pend); end
      if (m_pend) begin
        checks++; if (bus.memAddr !== m_addr) begin errors++; $display("FAIL rnd_memAddr c%0d: got %h want %h", c, bus.memAddr, m_addr); end
      end
      checks++; if (bus.byteValid !== exp_bv()) begin errors++; $display("FAIL rnd_byteValid c%0d: got %b want %b", c, bus.byteValid, exp_bv()); end
      checks++; if (bus.intD !== exp_intd()) begin errors++; $display("FAIL rnd_intD c%0d: got %h want %h", c, bus.intD, exp_intd()); end
      checks++; if (bus.pcOut !== m_pc) begin errors++; $display("FAIL rnd_pcOut c%0d: got %h want %h", c, bus.pcOut, m_pc); end
      tick();
    end
    bus.incPC  = 1'b0;
    bus.loadPC = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0005] = 8'hA5;
    mem[16'h8000] = 8'h18;
    mem[16'h2000] = 8'h3C;
    test_reset();
    test_fill();
    test_stream();
    test_redirect();
    test_wrap();
    test_hold();
    test_bypass();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
